// File: rtl/dog_sprite_pkg.sv
// Shared constants and types for the dog sprite path: sprite geometry, animation
// sizing, derived address widths and the palette index type.
package dog_sprite_pkg;

    localparam int SPR_W           = 32;
    localparam int SPR_H           = 32;
    localparam int NUM_FRAMES      = 4;
    localparam int FRAMES_PER_STEP = 8;

    localparam int COL_W  = $clog2(SPR_W);
    localparam int ROW_W  = $clog2(SPR_H);
    localparam int FRM_W  = $clog2(NUM_FRAMES);
    localparam int STEP_W = $clog2(FRAMES_PER_STEP);
    localparam int ADDR_W = FRM_W + ROW_W + COL_W;

    typedef logic [3:0] pal_idx_t;

    localparam pal_idx_t TRANSP_INDEX = 4'd0;

endpackage

// File: rtl/dog_sprite_fetch_if.sv
// Signal bundle between the raster/ROM side and the sprite fetch stage.
// The stage is free-running: no valid/ready handshake, one pixel per Clk with fixed 2-cycle latency.
interface dog_sprite_fetch_if;
    import dog_sprite_pkg::*;

    logic              frame_start;
    logic              active;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        DogX;
    logic [9:0]        DogY;
    logic              flip;
    logic              anim_en;
    logic [ADDR_W-1:0] rom_addr;
    pal_idx_t          rom_q;
    pal_idx_t          pixel_index;
    logic              pixel_valid;
    logic [FRM_W-1:0]  anim_frame;

    modport master (
        output frame_start, active, DrawX, DrawY, DogX, DogY, flip, anim_en, rom_q,
        input  rom_addr, pixel_index, pixel_valid, anim_frame
    );

    modport slave (
        input  frame_start, active, DrawX, DrawY, DogX, DogY, flip, anim_en, rom_q,
        output rom_addr, pixel_index, pixel_valid, anim_frame
    );

endinterface

// File: rtl/dog_sprite_fetch_anim_counter.sv
// Animation step/frame counter, advanced only on frame_start edges while anim_en is high.
module dog_anim_counter
    import dog_sprite_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_start,
    input  logic             anim_en,
    output logic [FRM_W-1:0] anim_frame
);

    logic [STEP_W-1:0] step_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            step_cnt   <= '0;
            anim_frame <= '0;
        end else if (frame_start && anim_en) begin
            if (step_cnt == STEP_W'(FRAMES_PER_STEP - 1)) begin
                step_cnt <= '0;
                if (anim_frame == FRM_W'(NUM_FRAMES - 1))
                    anim_frame <= '0;
                else
                    anim_frame <= anim_frame + 1'b1;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dog_sprite_fetch.sv
// Per-pixel dog sprite fetch: hit test and ROM addressing against frame-latched
// position, then a 2-stage pipeline producing palette index and opaque flag.
module dog_sprite_fetch
    import dog_sprite_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    dog_sprite_fetch_if.slave bus
);

    logic [9:0]        sx;
    logic [9:0]        sy;
    logic              sflip;
    logic              hit_d1;
    logic              hit_d2;
    logic              hit;
    logic [10:0]       x11;
    logic [10:0]       y11;
    logic [10:0]       sx11;
    logic [10:0]       sy11;
    logic [COL_W-1:0]  col_raw;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;

    dog_anim_counter u_anim (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(bus.frame_start),
        .anim_en    (bus.anim_en),
        .anim_frame (bus.anim_frame)
    );

    // 11-bit compares so a sprite near the right/bottom edge cannot wrap to column 0.
    always_comb begin
        x11  = {1'b0, bus.DrawX};
        y11  = {1'b0, bus.DrawY};
        sx11 = {1'b0, sx};
        sy11 = {1'b0, sy};
        hit  = bus.active
            && (x11 >= sx11) && (x11 < sx11 + 11'(SPR_W))
            && (y11 >= sy11) && (y11 < sy11 + 11'(SPR_H));
    end

    always_comb begin
        col_raw = COL_W'(bus.DrawX - sx);
        row     = ROW_W'(bus.DrawY - sy);
        col     = sflip ? (COL_W'(SPR_W - 1) - col_raw) : col_raw;
        addr    = {bus.anim_frame, row, col};
    end

    // Shadow position is swapped at frame_start; the pixel of that cycle still sees the old values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sx           <= '0;
            sy           <= '0;
            sflip        <= 1'b0;
            bus.rom_addr <= '0;
            hit_d1       <= 1'b0;
            hit_d2       <= 1'b0;
        end else begin
            if (bus.frame_start) begin
                sx    <= bus.DogX;
                sy    <= bus.DogY;
                sflip <= bus.flip;
            end
            bus.rom_addr <= hit ? addr : '0;
            hit_d1       <= hit;
            hit_d2       <= hit_d1;
        end
    end

    // rom_q is the ROM's output register, aligned with hit_d2.
    assign bus.pixel_index = hit_d2 ? bus.rom_q : TRANSP_INDEX;
    assign bus.pixel_valid = hit_d2 && (bus.rom_q != TRANSP_INDEX);

endmodule

// File: tb/tb_dog_sprite_fetch.sv
// Self-checking bench for dog_sprite_fetch with a behavioural sprite ROM and
// expected-value queues for the 1-cycle address and 2-cycle pixel outputs.
module tb_dog_sprite_fetch;
    import dog_sprite_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dog_sprite_fetch_if bus();

    dog_sprite_fetch dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] rom_word(input logic [11:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8];
    endfunction

    always @(posedge Clk) bus.rom_q <= rom_word(bus.rom_addr);

    // Reference state
    int m_sx = 0, m_sy = 0, m_flip = 0, m_frame = 0, m_step = 0;
    logic [9:0] pend_x = '0, pend_y = '0;
    bit pend_flip = 0, pend_anim = 0;

    logic [11:0] exp_addr_q[$];
    logic [4:0]  exp_pix_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit fs, input bit act, input logic [9:0] x, input logic [9:0] y);
        int xi, yi, col, row, a;
        bit h;
        logic [3:0] w;
        logic [4:0] p;
        @(negedge Clk);
        check_eq("anim_frame", 32'(bus.anim_frame), 32'(m_frame));
        if (exp_addr_q.size() == 1)
            check_eq("rom_addr", 32'(bus.rom_addr), 32'(exp_addr_q.pop_front()));
        if (exp_pix_q.size() == 2) begin
            p = exp_pix_q.pop_front();
            check_eq("pixel_index", 32'(bus.pixel_index), 32'(p[3:0]));
            check_eq("pixel_valid", 32'(bus.pixel_valid), 32'(p[4]));
        end
        xi = int'(x);
        yi = int'(y);
        h = act && xi >= m_sx && xi < m_sx + 32 && yi >= m_sy && yi < m_sy + 32;
        a = 0;
        if (h) begin
            col = xi - m_sx;
            row = yi - m_sy;
            if (m_flip != 0) col = 31 - col;
            a = m_frame * 1024 + row * 32 + col;
        end
        w = h ? rom_word(12'(a)) : 4'd0;
        exp_addr_q.push_back(12'(a));
        exp_pix_q.push_back({h && (w != 4'd0), w});
        bus.frame_start = fs;
        bus.active      = act;
        bus.DrawX       = x;
        bus.DrawY       = y;
        bus.DogX        = pend_x;
        bus.DogY        = pend_y;
        bus.flip        = pend_flip;
        bus.anim_en     = pend_anim;
        if (fs) begin
            m_sx   = int'(pend_x);
            m_sy   = int'(pend_y);
            m_flip = int'(pend_flip);
            if (pend_anim) begin
                if (m_step == FRAMES_PER_STEP - 1) begin
                    m_step  = 0;
                    m_frame = (m_frame + 1) % NUM_FRAMES;
                end else begin
                    m_step++;
                end
            end
        end
    endtask

    task automatic set_dog(input logic [9:0] x, input logic [9:0] y, input bit fl, input bit ae);
        pend_x = x; pend_y = y; pend_flip = fl; pend_anim = ae;
    endtask

    initial begin
        bus.frame_start = 0; bus.active = 0; bus.DrawX = '0; bus.DrawY = '0;
        bus.DogX = '0; bus.DogY = '0; bus.flip = 0; bus.anim_en = 0;
        #12;
        check_eq("reset_rom_addr", 32'(bus.rom_addr), 0);
        check_eq("reset_pixel_valid", 32'(bus.pixel_valid), 0);
        check_eq("reset_pixel_index", 32'(bus.pixel_index), 0);
        check_eq("reset_anim_frame", 32'(bus.anim_frame), 0);
        @(negedge Clk);
        Reset = 0;

        // Basic placement and corner addresses
        set_dog(10'd100, 10'd50, 0, 0);
        step(1, 0, '0, '0);
        step(0, 1, 10'd100, 10'd50);
        step(0, 1, 10'd131, 10'd81);
        check_eq("addr_origin", 32'(bus.rom_addr), 32'h000);
        step(0, 1, 10'd132, 10'd81);
        check_eq("addr_corner", 32'(bus.rom_addr), 32'h3FF);
        step(0, 1, 10'd99, 10'd50);
        check_eq("addr_past_right", 32'(bus.rom_addr), 32'h000);
        for (int i = 0; i < 20; i++)
            step(0, 1, 10'(100 + $urandom_range(0, 31)), 10'(50 + $urandom_range(0, 31)));

        // Horizontal flip
        set_dog(10'd100, 10'd50, 1, 0);
        step(1, 0, '0, '0);
        step(0, 1, 10'd100, 10'd51);
        step(0, 0, '0, '0);
        check_eq("addr_flip", 32'(bus.rom_addr), 32'h03F);

        // Animation: 8 pulses advance one frame, 32 wrap back to 0
        set_dog(10'd100, 10'd50, 1, 1);
        for (int i = 0; i < 8; i++) step(1, 0, '0, '0);
        set_dog(10'd100, 10'd50, 1, 0);
        step(0, 1, 10'd100, 10'd50);
        check_eq("anim_frame_1", 32'(bus.anim_frame), 1);
        step(0, 0, '0, '0);
        check_eq("addr_frame1", 32'(bus.rom_addr), 32'h41F);
        set_dog(10'd100, 10'd50, 1, 1);
        for (int i = 0; i < 24; i++) step(1, 0, '0, '0);
        set_dog(10'd100, 10'd50, 1, 0);
        step(0, 0, '0, '0);
        check_eq("anim_frame_wrap", 32'(bus.anim_frame), 0);

        // Right screen edge
        set_dog(10'd1000, 10'd50, 0, 0);
        step(1, 0, '0, '0);
        step(0, 1, 10'd1023, 10'd50);
        step(0, 1, 10'd7, 10'd50);
        check_eq("addr_right_edge", 32'(bus.rom_addr), 32'h017);
        step(0, 0, '0, '0);
        check_eq("addr_no_wrap", 32'(bus.rom_addr), 32'h000);

        // Random traffic with occasional frame_start and new sprite state
        for (int i = 0; i < 300; i++) begin
            bit fs;
            fs = ($urandom_range(0, 15) == 0);
            if (fs)
                set_dog(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 500)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step(fs, 1'($urandom_range(0, 7) != 0),
                 10'(m_sx + $urandom_range(0, 40) - 4), 10'(m_sy + $urandom_range(0, 40) - 4));
        end

        // Reset mid-line while an opaque pixel is on the output
        set_dog(10'd200, 10'd100, 0, 0);
        step(1, 0, '0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, 10'd205, 10'd100);
        check_eq("pre_reset_valid", 32'(bus.pixel_valid), 1);
        #2 Reset = 1;
        #1;
        check_eq("mid_reset_valid", 32'(bus.pixel_valid), 0);
        check_eq("mid_reset_addr", 32'(bus.rom_addr), 0);
        check_eq("mid_reset_frame", 32'(bus.anim_frame), 0);
        exp_addr_q.delete();
        exp_pix_q.delete();
        m_sx = 0; m_sy = 0; m_flip = 0; m_frame = 0; m_step = 0;
        repeat (2) @(negedge Clk);
        Reset = 0;
        step(1, 0, '0, '0);
        for (int i = 0; i < 4; i++) step(0, 1, 10'd205, 10'd100);
        for (int i = 0; i < 3; i++) step(0, 0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
